// File: rtl/ofs_fim_axis_arb_pkg.sv
// Shared types and the rotate-priority search used by the AXI-Stream round-robin arbiter.
package ofs_fim_axis_arb_pkg;

  localparam int MAX_PORTS  = 16;
  localparam int MAX_PORT_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [MAX_PORT_W-1:0] idx;
  } rr_pick_t;

  // First asserted req searching upward from (last+1), wrapping at n (1..MAX_PORTS).
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0]  req,
                                       input logic [MAX_PORT_W-1:0] last,
                                       input int                    n);
    rr_pick_t r;
    int       p;
    r = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      p = (int'(last) + k) % n;
      if ((k <= n) && !r.found && req[p[MAX_PORT_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = p[MAX_PORT_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ofs_fim_rr_picker.sv
// Combinational rotate-priority encoder: picks the next requester after the last owner.
module ofs_fim_rr_picker
  import ofs_fim_axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_W-1:0]    last_i,
  output logic [PORT_W-1:0]    grant_o,
  output logic                 found_o
);

  logic [MAX_PORTS-1:0]  req_ext;
  logic [MAX_PORT_W-1:0] last_ext;
  rr_pick_t              pick;
  logic                  unused_pick_bits;

  always_comb begin
    req_ext                   = '0;
    req_ext[NUM_PORTS-1:0]    = req_i;
    last_ext                  = '0;
    last_ext[PORT_W-1:0]      = last_i;
    pick                      = rr_pick(req_ext, last_ext, NUM_PORTS);
  end

  assign grant_o          = pick.idx[PORT_W-1:0];
  assign found_o          = pick.found;
  assign unused_pick_bits = ^pick.idx;

endmodule

// File: rtl/ofs_fim_axis_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream sources onto one registered sink.
module ofs_fim_axis_rr_arbiter
  import ofs_fim_axis_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int PORT_W      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  output logic [NUM_PORTS-1:0]                 s_tready,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]     s_tuser_vendor,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [TDATA_WIDTH-1:0]               m_tdata,
  output logic [TDATA_WIDTH/8-1:0]             m_tkeep,
  output logic                                 m_tlast,
  output logic [TUSER_WIDTH-1:0]               m_tuser_vendor,
  output logic [PORT_W-1:0]                    m_tid,
  output logic                                 busy
);

  localparam int KEEP_W = TDATA_WIDTH / 8;

  arb_state_e              state_q, state_d;
  logic [PORT_W-1:0]       owner_q, owner_d;
  logic [PORT_W-1:0]       last_q, last_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [TDATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic [KEEP_W-1:0]       m_tkeep_q, m_tkeep_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [TUSER_WIDTH-1:0]  m_tuser_q, m_tuser_d;
  logic [PORT_W-1:0]       m_tid_q, m_tid_d;

  logic                    out_free;
  logic [PORT_W-1:0]       grant;
  logic                    found;
  logic [PORT_W-1:0]       sel;
  logic                    sel_req;
  logic                    sel_valid;
  logic [TDATA_WIDTH-1:0]  sel_data;
  logic [KEEP_W-1:0]       sel_keep;
  logic                    sel_last;
  logic [TUSER_WIDTH-1:0]  sel_user;
  logic                    accept;

  ofs_fim_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_picker (
    .req_i   (s_tvalid),
    .last_i  (last_q),
    .grant_o (grant),
    .found_o (found)
  );

  assign out_free = ~m_tvalid_q | m_tready;

  // While locked the owner is offered ready regardless of its valid, so bubbles keep the lock.
  assign sel     = (state_q == LOCKED) ? owner_q : grant;
  assign sel_req = (state_q == LOCKED) ? 1'b1 : found;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_user  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == PORT_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_data  = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
        sel_last  = s_tlast[i];
        sel_user  = s_tuser_vendor[i*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_tready[i] = ~rst & out_free & sel_req & (sel == PORT_W'(i));
    end
  end

  assign accept = ~rst & out_free & sel_req & sel_valid;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tid_d    = m_tid_q;
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = sel_data;
      m_tkeep_d  = sel_keep;
      m_tlast_d  = sel_last;
      m_tuser_d  = sel_user;
      m_tid_d    = sel;
      if (state_q == IDLE) begin
        last_d = sel;
      end
      if (sel_last) begin
        state_d = IDLE;
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end else if (out_free) begin
      m_tvalid_d = 1'b0;
    end
  end

  // Output register stage; reset drops any in-flight beat and the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= PORT_W'(NUM_PORTS - 1);
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_tvalid       = m_tvalid_q;
  assign m_tdata        = m_tdata_q;
  assign m_tkeep        = m_tkeep_q;
  assign m_tlast        = m_tlast_q;
  assign m_tuser_vendor = m_tuser_q;
  assign m_tid          = m_tid_q;
  assign busy           = (state_q == LOCKED);

endmodule

// File: tb/tb_ofs_fim_axis_rr_arbiter.sv
// Bench for ofs_fim_axis_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ofs_fim_axis_rr_arbiter;

  localparam int NP        = 4;
  localparam int DW        = 32;
  localparam int KW        = DW / 8;
  localparam int UW        = 10;
  localparam int PW        = 2;
  localparam int RND_LIMIT = 20000;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]   src_data [NP];
  logic [KW-1:0]   src_keep [NP];
  logic [UW-1:0]   src_user [NP];
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP*UW-1:0] s_tuser_vendor;
  logic            m_tvalid, m_tready, m_tlast, busy;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser_vendor;
  logic [PW-1:0]   m_tid;

  always #5 clk = ~clk;

  always_comb begin
    s_tdata        = '0;
    s_tkeep        = '0;
    s_tuser_vendor = '0;
    for (int i = 0; i < NP; i++) begin
      s_tdata[i*DW +: DW]        = src_data[i];
      s_tkeep[i*KW +: KW]        = src_keep[i];
      s_tuser_vendor[i*UW +: UW] = src_user[i];
    end
  end

  ofs_fim_axis_rr_arbiter #(
    .NUM_PORTS   (NP),
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .s_tkeep        (s_tkeep),
    .s_tlast        (s_tlast),
    .s_tuser_vendor (s_tuser_vendor),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tkeep        (m_tkeep),
    .m_tlast        (m_tlast),
    .m_tuser_vendor (m_tuser_vendor),
    .m_tid          (m_tid),
    .busy           (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk(name, act === exp, act, exp);
  endtask

  // Source generator state (randomized phases)
  int g_beat [NP];
  int g_len  [NP];
  int g_pkt  [NP];
  bit g_en   [NP];
  int g_flen, g_bub, g_left;
  bit rnd_phase = 1'b0;

  // Reference model and scoreboard state, owned by the monitor
  int            own, lown, mo_tid, cand;
  bit            mo_v, free;
  beat_t         mo_b, ob;
  logic [NP-1:0] er, acc, acc_q;
  logic [PW+$bits(beat_t)-1:0] ap, ep;
  beat_t         sbq [NP][$];
  bit            prev_open;
  int            prev_tid, pkts_out, maxw;
  int            wcnt [NP];

  function automatic beat_t src_beat(input int p);
    return beat_t'{src_data[p], src_keep[p], s_tlast[p], src_user[p]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      own = -1; lown = NP - 1; mo_v = 1'b0; mo_b = '0; mo_tid = 0;
      acc_q = '0; prev_open = 1'b0;
      for (int p = 0; p < NP; p++) sbq[p].delete();
    end else begin
      // Expected grant from the owner or a rotating search after the last owner
      free = !mo_v || m_tready;
      cand = -1;
      if (own >= 0) cand = own;
      else for (int k = 1; k <= NP; k++) if (cand < 0 && s_tvalid[(lown + k) % NP]) cand = (lown + k) % NP;
      er = '0;
      if (free && cand >= 0) er[cand] = 1'b1;
      ap = m_tvalid ? {m_tid, m_tdata, m_tkeep, m_tlast, m_tuser_vendor} : '0;
      ep = mo_v ? {PW'(mo_tid), mo_b} : '0;
      chk_eq("cycle_model", {s_tready, m_tvalid, busy, ap}, {er, mo_v, own >= 0, ep});

      if (m_tvalid && m_tready) begin
        ob = beat_t'{m_tdata, m_tkeep, m_tlast, m_tuser_vendor};
        if (sbq[m_tid].size() == 0) chk("sb_order", 1'b0, {m_tid, ob}, 0);
        else begin
          chk("sb_order", (sbq[m_tid][0] === ob) && (!prev_open || prev_tid == int'(m_tid)),
              {m_tid, ob}, {prev_open ? PW'(prev_tid) : m_tid, sbq[m_tid][0]});
          void'(sbq[m_tid].pop_front());
        end
        prev_open = !m_tlast;
        prev_tid  = int'(m_tid);
        if (m_tlast) pkts_out++;
      end

      acc = s_tvalid & s_tready;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) begin
          sbq[p].push_back(src_beat(p));
          if (rnd_phase && g_beat[p] == 0) begin
            for (int q = 0; q < NP; q++) if (q != p && s_tvalid[q] && g_beat[q] == 0) wcnt[q]++;
            if (wcnt[p] > maxw) maxw = wcnt[p];
            wcnt[p] = 0;
          end
        end
      end
      acc_q = acc;

      if (free) begin
        if (cand >= 0 && s_tvalid[cand]) begin
          mo_v = 1'b1; mo_b = src_beat(cand); mo_tid = cand;
          if (own < 0) lown = cand;
          own = s_tlast[cand] ? -1 : cand;
        end else mo_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input bit v, input logic [DW-1:0] d, input bit l);
    s_tvalid[p] = v;
    src_data[p] = d;
    src_keep[p] = '1;
    src_user[p] = UW'(p + 1);
    s_tlast[p]  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, 1'b0);
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic gen_init(input logic [NP-1:0] en, input int flen, input int bub, input int npk);
    g_flen = flen; g_bub = bub; g_left = npk;
    for (int p = 0; p < NP; p++) begin
      g_en[p] = en[p]; g_beat[p] = 0; g_pkt[p] = 0; wcnt[p] = 0;
      g_len[p] = (flen > 0) ? flen : int'($urandom_range(1, 4));
    end
  endtask

  task automatic gen_tick();
    for (int p = 0; p < NP; p++) begin
      if (acc_q[p]) begin
        if (g_beat[p] == g_len[p] - 1) begin
          g_beat[p] = 0;
          g_pkt[p]++;
          g_len[p] = (g_flen > 0) ? g_flen : int'($urandom_range(1, 4));
        end else g_beat[p]++;
      end
      if (!(s_tvalid[p] && !acc_q[p])) begin
        if (g_en[p] && (g_beat[p] != 0 || g_left > 0) && (int'($urandom_range(0, 99)) >= g_bub)) begin
          if (g_beat[p] == 0) g_left--;
          s_tvalid[p] = 1'b1;
          src_data[p] = {4'(p), 16'(g_pkt[p]), 12'(g_beat[p])};
          src_keep[p] = KW'(g_pkt[p] + g_beat[p] + 1);
          src_user[p] = UW'(g_pkt[p] * 7 + p);
          s_tlast[p]  = (g_beat[p] == g_len[p] - 1);
        end else s_tvalid[p] = 1'b0;
      end
    end
  endtask

  function automatic bit gen_quiet();
    for (int p = 0; p < NP; p++) if (g_beat[p] != 0 || s_tvalid[p]) return 1'b0;
    return g_left == 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DW+PW+2:0] saved;
    int               b, cyc;
    bit               v;
    rst = 1'b0;
    m_tready = 1'b1;
    for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, 1'b0);
    #1 rst = 1'b1;
    neg();
    chk_eq("reset_outputs", {m_tvalid, m_tlast, m_tid, busy, s_tready, m_tdata, m_tkeep, m_tuser_vendor}, 0);
    do_reset();

    // Single 3-beat packet on port 0
    drive(0, 1'b1, 32'hA, 1'b0); neg();
    chk_eq("t1_ready_first", s_tready, 4'b0001);
    step(); drive(0, 1'b1, 32'hB, 1'b0); neg();
    chk_eq("t1_beat_a", {m_tvalid, m_tdata, m_tid, busy}, {1'b1, 32'hA, 2'd0, 1'b1});
    step(); drive(0, 1'b1, 32'hC, 1'b1); neg();
    chk_eq("t1_beat_b", {m_tvalid, m_tdata, m_tid, busy}, {1'b1, 32'hB, 2'd0, 1'b1});
    step(); drive(0, 1'b0, '0, 1'b0); neg();
    chk_eq("t1_beat_c", {m_tvalid, m_tdata, m_tlast, busy}, {1'b1, 32'hC, 1'b1, 1'b0});
    step(); neg();
    chk_eq("t1_empty", m_tvalid, 1'b0);

    // Every port holds single-beat packets: strict rotation, no gaps
    do_reset();
    for (int p = 0; p < NP; p++) drive(p, 1'b1, DW'(32'h100 + p), 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(); neg();
      chk_eq("t2_rotation", {m_tvalid, m_tid}, {1'b1, PW'(i % NP)});
    end
    step();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, 1'b0);

    // Port 1 locked through a 2-cycle bubble while port 2 waits
    do_reset();
    b = 0;
    for (int c = 0; c < 7; c++) begin
      v = !(c == 2 || c == 3 || c == 6);
      drive(1, v, DW'(32'h10 + b), b == 3);
      drive(2, 1'b1, 32'h200, 1'b1);
      neg();
      chk_eq("t3_lock", {s_tready, busy}, {(c == 6) ? 4'b0100 : 4'b0010, (c >= 1 && c <= 5)});
      if (v) b++;
      step();
    end
    for (int p = 0; p < NP; p++) drive(p, 1'b0, '0, 1'b0);

    // Sink stall for 5 cycles in the middle of a 6-beat packet
    do_reset();
    gen_init(4'b0001, 6, 0, 1);
    pkts_out = 0;
    saved = '0;
    gen_tick();
    for (int c = 0; c < 25; c++) begin
      m_tready = !(c >= 3 && c <= 7);
      neg();
      if (c == 3) saved = {m_tvalid, m_tdata, m_tlast, m_tid};
      if (c >= 4 && c <= 7)
        chk_eq("t4_stall_hold", {s_tready, m_tvalid, m_tdata, m_tlast, m_tid}, {4'b0000, 1'b1, saved[DW+PW:0]});
      step();
      gen_tick();
    end
    chk_eq("t4_drained", {32'(sbq[0].size()), 32'(pkts_out)}, {32'd0, 32'd1});

    // Reset mid-packet on port 3
    do_reset();
    drive(3, 1'b1, 32'h300, 1'b0); neg();
    chk_eq("t5_grant3", s_tready, 4'b1000);
    step(); drive(3, 1'b1, 32'h301, 1'b0); drive(0, 1'b1, 32'h400, 1'b1); neg();
    chk_eq("t5_locked", {s_tready, busy}, {4'b1000, 1'b1});
    step(); rst = 1'b1; drive(3, 1'b0, '0, 1'b0); neg();
    chk_eq("t5_in_reset", {m_tvalid, busy, s_tready}, 0);
    step(); rst = 1'b0; neg();
    chk_eq("t5_grant0", s_tready, 4'b0001);
    step(); drive(0, 1'b0, '0, 1'b0); neg();
    chk_eq("t5_out0", {m_tvalid, m_tid, m_tdata}, {1'b1, 2'd0, 32'h400});

    // Randomized traffic on all ports, 1000 packets
    do_reset();
    gen_init(4'b1111, 0, 20, 1000);
    pkts_out = 0;
    maxw = 0;
    rnd_phase = 1'b1;
    cyc = 0;
    gen_tick();
    m_tready = ($urandom_range(0, 3) != 0);
    while (cyc < RND_LIMIT) begin
      step();
      gen_tick();
      m_tready = ($urandom_range(0, 3) != 0);
      cyc++;
      if (gen_quiet()) break;
    end
    m_tready = 1'b1;
    repeat (4) step();
    rnd_phase = 1'b0;
    chk_eq("rnd_timeout", cyc >= RND_LIMIT, 1'b0);
    chk_eq("rnd_packets", pkts_out, 1000);
    chk_eq("rnd_queues_empty", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
    chk("rnd_max_wait", maxw <= NP - 1, maxw, NP - 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
